// File: rtl/sd_dac_multi_if.sv
// Sample-set handshake between an audio source and the sigma-delta DAC.
// The source drives data/valid; the DAC returns ready.
interface sd_dac_multi_if #(
  parameter int CHANNELS = 2,
  parameter int C_BITS   = 16
);
  logic [CHANNELS*C_BITS-1:0] dac_i;
  logic                       dac_valid_i;
  logic                       dac_ready_o;

  modport master (output dac_i, output dac_valid_i, input dac_ready_o);
  modport slave  (input dac_i, input dac_valid_i, output dac_ready_o);
endinterface

// File: rtl/sd_dac_multi.sv
// Multi-channel 1st/2nd-order sigma-delta DAC with sample-and-hold input and soft mute ramp.
// One sample set per RATE_DIV cycles (ready low in between); modulation never stalls.
module sd_dac_multi #(
  parameter int CHANNELS  = 2,
  parameter int C_BITS    = 16,
  parameter int SIGNED_IN = 1,
  parameter int ORDER     = 1,
  parameter int RATE_DIV  = 4,
  parameter int RAMP_CYC  = 2
) (
  input  logic                clk_i,
  input  logic                res_n_i,
  sd_dac_multi_if.slave       bus,
  input  logic                mute_i,
  output logic [CHANNELS-1:0] dac_o
);

  localparam int AW = $clog2(C_BITS + 1);
  localparam int RW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int PW = (RAMP_CYC > 1) ? $clog2(RAMP_CYC) : 1;
  localparam int IW = C_BITS + 4;
  localparam logic [C_BITS-1:0] HOLD_ZERO =
    (SIGNED_IN != 0) ? {C_BITS{1'b0}} : {1'b1, {(C_BITS-1){1'b0}}};

  logic [AW-1:0]              r_att;
  logic [PW-1:0]              r_ramp;
  logic [RW-1:0]              r_rate;
  logic                       r_ready;
  logic [CHANNELS*C_BITS-1:0] r_hold;
  logic                       w_accept;

  assign w_accept        = bus.dac_valid_i && r_ready;
  assign bus.dac_ready_o = r_ready;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_ready <= 1'b0;
      r_rate  <= '0;
    end else if (w_accept) begin
      if (RATE_DIV > 1) begin
        r_ready <= 1'b0;
        r_rate  <= RW'(RATE_DIV - 1);
      end
    end else if (!r_ready) begin
      // rate counter is zero out of reset, so ready rises on the first edge
      if (r_rate <= RW'(1)) begin
        r_ready <= 1'b1;
        r_rate  <= '0;
      end else begin
        r_rate <= r_rate - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_hold <= {CHANNELS{HOLD_ZERO}};
    end else if (w_accept) begin
      r_hold <= bus.dac_i;
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_ramp <= '0;
      r_att  <= AW'(C_BITS);
    end else if (r_ramp == PW'(RAMP_CYC - 1)) begin
      r_ramp <= '0;
      if (mute_i && (r_att != AW'(C_BITS))) begin
        r_att <= r_att + 1'b1;
      end else if (!mute_i && (r_att != '0)) begin
        r_att <= r_att - 1'b1;
      end
    end else begin
      r_ramp <= r_ramp + 1'b1;
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [C_BITS-1:0] w_raw, w_s, w_a, w_u;
    logic              r_dac;

    assign w_raw = r_hold[n*C_BITS +: C_BITS];
    assign w_s   = (SIGNED_IN != 0) ? w_raw : {~w_raw[C_BITS-1], w_raw[C_BITS-2:0]};
    // full attenuation must be true silence, not the -1 an arithmetic shift leaves
    assign w_a   = (r_att >= AW'(C_BITS)) ? '0 : ($signed(w_s) >>> r_att);
    assign w_u   = {~w_a[C_BITS-1], w_a[C_BITS-2:0]};
    assign dac_o[n] = r_dac;

    if (ORDER == 1) begin : g_o1
      logic [C_BITS:0] r_acc;

      always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
          r_acc <= '0;
          r_dac <= 1'b0;
        end else begin
          r_acc <= {1'b0, r_acc[C_BITS-1:0]} + {1'b0, w_u};
          r_dac <= r_acc[C_BITS];
        end
      end
    end else begin : g_o2
      localparam logic signed [IW+1:0] SMAX = (IW+2)'((1 << (IW - 1)) - 1);
      localparam logic signed [IW+1:0] SMIN = -SMAX - 1;
      localparam logic signed [IW+1:0] FB   = (IW+2)'((1 << C_BITS) - 1);

      logic signed [IW-1:0] r_i1, r_i2;
      logic signed [IW+1:0] w_ux, w_fb, w_i1x, w_i2x;

      function automatic logic signed [IW-1:0] f_sat(input logic signed [IW+1:0] v);
        if (v > SMAX)      f_sat = SMAX[IW-1:0];
        else if (v < SMIN) f_sat = SMIN[IW-1:0];
        else               f_sat = v[IW-1:0];
      endfunction

      assign w_ux  = $signed({{(IW+2-C_BITS){1'b0}}, w_u});
      assign w_fb  = r_dac ? FB : '0;
      assign w_i1x = $signed({{2{r_i1[IW-1]}}, r_i1}) + w_ux - w_fb;
      assign w_i2x = $signed({{2{r_i2[IW-1]}}, r_i2}) + $signed({{2{r_i1[IW-1]}}, r_i1}) - w_fb;

      always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
          r_i1  <= '0;
          r_i2  <= '0;
          r_dac <= 1'b0;
        end else begin
          r_i1  <= f_sat(w_i1x);
          r_i2  <= f_sat(w_i2x);
          r_dac <= ~r_i2[IW-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_dac_multi.sv
// Bench for sd_dac_multi: a 2-channel ORDER=1 instance for handshake, ramp, mute, reset
// and density checks, plus a 1-channel ORDER=2 instance for full-scale step behaviour.
module tb_sd_dac_multi;

  logic       clk = 1'b0;
  logic       res_n = 1'b1;
  logic       mute = 1'b0;
  logic       mute2 = 1'b0;
  logic [1:0] dac1;
  logic [0:0] dac2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string name;
    int    lo;
    int    hi;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [15:0] c0;
    logic [15:0] c1;
    int          e0;
    int          e1;
  } vec_t;
  vec_t vecs[5];

  int exp_seq[10] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0};

  always #5 clk = ~clk;

  sd_dac_multi_if #(.CHANNELS(2), .C_BITS(16)) bus1 ();
  sd_dac_multi_if #(.CHANNELS(1), .C_BITS(16)) bus2 ();

  sd_dac_multi #(
    .CHANNELS(2), .C_BITS(16), .SIGNED_IN(1), .ORDER(1), .RATE_DIV(4), .RAMP_CYC(2)
  ) dut1 (
    .clk_i(clk), .res_n_i(res_n), .bus(bus1), .mute_i(mute), .dac_o(dac1)
  );

  sd_dac_multi #(
    .CHANNELS(1), .C_BITS(16), .SIGNED_IN(1), .ORDER(2), .RATE_DIV(4), .RAMP_CYC(2)
  ) dut2 (
    .clk_i(clk), .res_n_i(res_n), .bus(bus2), .mute_i(mute2), .dac_o(dac2)
  );

  function automatic void chk(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endfunction

  task automatic pop_chk(input int act);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", act, 1, 0);
    end else begin
      e = sbq.pop_front();
      chk(e.name, act, e.lo, e.hi);
    end
  endtask

  task automatic send1(input logic [15:0] c0, input logic [15:0] c1);
    int k = 0;
    @(negedge clk);
    while (!bus1.dac_ready_o && k < 16) begin
      @(negedge clk);
      k++;
    end
    if (!bus1.dac_ready_o) chk("send1_ready_timeout", 0, 1, 1);
    bus1.dac_i       = {c1, c0};
    bus1.dac_valid_i = 1'b1;
    @(negedge clk);
    bus1.dac_valid_i = 1'b0;
  endtask

  task automatic send2(input logic [15:0] c0);
    int k = 0;
    @(negedge clk);
    while (!bus2.dac_ready_o && k < 16) begin
      @(negedge clk);
      k++;
    end
    if (!bus2.dac_ready_o) chk("send2_ready_timeout", 0, 1, 1);
    bus2.dac_i       = c0;
    bus2.dac_valid_i = 1'b1;
    @(negedge clk);
    bus2.dac_valid_i = 1'b0;
  endtask

  task automatic count1(input int n, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    repeat (n) begin
      @(negedge clk);
      c0 += int'(dac1[0]);
      c1 += int'(dac1[1]);
    end
  endtask

  task automatic count2(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      c += int'(dac2[0]);
    end
  endtask

  task automatic wait_att(input int target, input string name);
    int k = 0;
    while (int'(dut1.r_att) != target && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(name, int'(dut1.r_att), target, target);
  endtask

  // Called with reset asserted: checks reset state, releases, checks the soft start.
  task automatic ramp_check(input string tag);
    int k = 0;
    int o0 = 0;
    int o1 = 0;
    chk({tag, "_rst_dac"}, int'(dac1), 0, 0);
    chk({tag, "_rst_ready"}, int'(bus1.dac_ready_o), 0, 0);
    chk({tag, "_rst_att"}, int'(dut1.r_att), 16, 16);
    @(negedge clk);
    res_n = 1'b1;
    while (k < 40) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) chk({tag, "_ready_first_edge"}, int'(bus1.dac_ready_o), 1, 1);
      o0 += int'(dac1[0]);
      o1 += int'(dac1[1]);
      if (int'(dut1.r_att) == 0) break;
    end
    chk({tag, "_att0_cycles"}, k, 32, 32);
    chk({tag, "_ramp_dens_ch0"}, o0, 15, 17);
    chk({tag, "_ramp_dens_ch1"}, o1, 15, 17);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, c, k, prev, cur;
    int seq[$];

    vecs[0] = '{16'h0000, 16'h0000, 512, 512};
    vecs[1] = '{16'h4000, 16'hC000, 768, 256};
    vecs[2] = '{16'h7FFF, 16'h8000, 1024, 0};
    vecs[3] = '{16'h1000, 16'hF000, 576, 448};
    vecs[4] = '{16'hC000, 16'h4000, 256, 768};

    bus1.dac_i = '0;
    bus1.dac_valid_i = 1'b0;
    bus2.dac_i = '0;
    bus2.dac_valid_i = 1'b0;

    #1 res_n = 1'b0;
    #1;
    ramp_check("boot");
    repeat (3) @(negedge clk);
    res_n = 1'b0;
    #1;
    ramp_check("init");

    // ready cadence with valid held high
    @(negedge clk);
    bus1.dac_i = '0;
    bus1.dac_valid_i = 1'b1;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rate_ready_%0d", i), int'(bus1.dac_ready_o), (i % 4 == 0) ? 1 : 0, (i % 4 == 0) ? 1 : 0);
      if (bus1.dac_ready_o) k++;
      @(negedge clk);
    end
    bus1.dac_valid_i = 1'b0;
    chk("rate_accepts", k, 4, 4);

    for (int i = 0; i < 5; i++) begin
      send1(vecs[i].c0, vecs[i].c1);
      sbq.push_back('{$sformatf("vec%0d_ch0", i), vecs[i].e0 - 1, vecs[i].e0 + 1});
      sbq.push_back('{$sformatf("vec%0d_ch1", i), vecs[i].e1 - 1, vecs[i].e1 + 1});
      repeat (8) @(negedge clk);
      count1(1024, c0, c1);
      pop_chk(c0);
      pop_chk(c1);
    end

    // full attenuation gives silence even for the extreme codes
    mute = 1'b1;
    wait_att(16, "mute_att_full");
    send1(16'h7FFF, 16'h8000);
    sbq.push_back('{"mute_full_ch0", 511, 513});
    sbq.push_back('{"mute_full_ch1", 511, 513});
    repeat (8) @(negedge clk);
    count1(1024, c0, c1);
    pop_chk(c0);
    pop_chk(c1);

    // mute reversal mid-ramp
    mute = 1'b0;
    wait_att(0, "unmute_att_zero");
    @(negedge clk);
    mute = 1'b1;
    prev = int'(dut1.r_att);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      cur = int'(dut1.r_att);
      if (cur != prev) begin
        seq.push_back(cur);
        if (cur == 5 && mute) mute = 1'b0;
        prev = cur;
        if (cur == 0) break;
      end
    end
    chk("reverse_len", seq.size(), 10, 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("reverse_step_%0d", i), (i < seq.size()) ? seq[i] : -1, exp_seq[i], exp_seq[i]);
    end

    // asynchronous reset mid-stream
    send1(16'h4000, 16'h4000);
    k = 0;
    while (dac1[0] != 1'b1 && k < 16) begin
      @(negedge clk);
      k++;
    end
    chk("arst_pre_dac_high", int'(dac1[0]), 1, 1);
    #1 res_n = 1'b0;
    #1;
    chk("arst_dac_now", int'(dac1), 0, 0);
    chk("arst_ready_now", int'(bus1.dac_ready_o), 0, 0);
    repeat (2) @(negedge clk);
    ramp_check("rerst");

    fork
      begin
        int a0, a1;
        send1(16'h4000, 16'hC000);
        sbq.push_back('{"long_ch0", 49151, 49153});
        sbq.push_back('{"long_ch1", 16383, 16385});
        repeat (8) @(negedge clk);
        count1(65536, a0, a1);
        pop_chk(a0);
        pop_chk(a1);
      end
      begin
        int b, n;
        send2(16'h7FFF);
        repeat (256) @(negedge clk);
        count2(4096, b);
        chk("o2_pos_full_density", b, 4092, 4096);
        send2(16'h8000);
        n = 0;
        while (n < 80) begin
          @(negedge clk);
          n++;
          if (dac2[0] == 1'b0) break;
        end
        chk("o2_step_recover_cycles", n, 1, 64);
        repeat (64) @(negedge clk);
        count2(4096, b);
        chk("o2_neg_full_density", b, 0, 4);
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
